lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store initiator that drives the data-memory port (we, word address, write data, 32-bit byte-lane write mask, combinational read data).
- Accepts one RV32 load/store per handshake from the core's MEM stage.
- Generates byte-lane masks and shifted store data, and splits misaligned accesses into two word accesses.
- Merges and sign/zero-extends load data, then returns a single response.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split accesses that cross a word boundary; 0 = answer misaligned requests with resp_err and no memory access.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts the response
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  illegal funct3, or misaligned access with ALLOW_MISALIGNED = 0
- mem_we  out  1  memory write enable
- mem_a  out  32  word-aligned address (bits [1:0] = 00)
- mem_wd  out  32  lane-shifted write data
- mem_write_mask  out  32  byte-lane mask; each lane is 0x00 or 0xFF
- mem_rd  in  32  combinational read data for mem_a

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, resp_valid 0, resp_rdata 0, resp_err 0, mem_we 0, mem_a 0, mem_wd 0, mem_write_mask 0.
- Register capture: on req_valid & req_ready, capture we, funct3, addr, wdata.
- Derived values:
  - off = addr[1:0]
  - size = 1/2/4 bytes
  - split = off + size > 4
  - be = 1, 3 or F (per byte of the access)
- Lane placement:
  - 64-bit data = {32'b0, wdata} << 8*off; 8-bit enable = be << off.
  - The low half feeds access 0; the high half feeds access 1.
  - mem_write_mask expands each enable bit to 8 bits.
- States and transitions:
  - IDLE -> ACC0 on accept.
  - IDLE -> RESP with err = 1 on accept if funct3 is illegal (011, 110, 111; or any value > 010 with we = 1).
  - IDLE -> RESP with err = 1 if split and ALLOW_MISALIGNED = 0.
  - ACC0 -> ACC1 if split, else -> RESP.
  - ACC1 -> RESP.
  - RESP -> IDLE when resp_ready.
- Accesses:
  - ACC0: mem_a = {addr[31:2], 2'b00}; mem_we = we.
  - ACC1: mem_a = {addr[31:2], 2'b00} + 4, wrapping 0xFFFFFFFC -> 0x00000000.
  - Loads: latch mem_rd at the end of each ACC cycle.
  - Outside ACC states: mem_we = 0, mem_write_mask = 0.
- Load result:
  - Merge {rd1, rd0} >> 8*off; for non-split accesses rd1 is ignored.
  - Take the low size bytes.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Latency from the accept edge:
  - Aligned: resp_valid 2 cycles later.
  - Split: 3 cycles later.
  - Error: 1 cycle later.
- Response handshake: resp_valid, resp_rdata and resp_err are held stable until resp_ready. Back-to-back throughput is at best one request per 3 cycles (aligned).
- Error responses: no mem_we pulse; resp_rdata = 0.
- Reset during an operation: return to IDLE at the next edge. Any store word already written is not undone. No response is issued.
- Simultaneous events:
  - req_valid is ignored outside IDLE.
  - In RESP with resp_ready, the next request is not accepted in the same cycle.

Decomposition:
- Package lsu_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU)
  - the state enum (IDLE, ACC0, ACC1, RESP)
  - helper size_of(funct3)
- One combinational sub-module, lsu_align, holds the lane-placement datapath (wdata/be -> 64-bit data and mask) and the load-merge/extend datapath.
- lsu_ctrl keeps the FSM and the registers.

Test Plan:
- SW addr 0x100, data 0xDEADBEEF -> one ACC cycle: mem_a 0x100, mem_wd 0xDEADBEEF, mask 0xFFFFFFFF, mem_we 1; resp_valid 2 cycles after accept, err 0.
- SB addr 0x103, data 0x000000AB -> mem_a 0x100, mem_wd 0xAB000000, mask 0xFF000000; single write.
- With mem words [0x100] = 0x80FF1234 and [0x104] = 0x00000056, LH at 0x103 -> two reads (0x100, 0x104) -> resp_rdata 0x00005680; LB at 0x102 -> 0xFFFFFFFF; LBU at 0x103 -> 0x00000080.
- SW addr 0xFFFFFFFE, data 0x11223344 -> ACC0 mem_a 0xFFFFFFFC, wd 0x33440000, mask 0xFFFF0000; ACC1 mem_a 0x00000000, wd 0x00001122, mask 0x0000FFFF.
- Error cases:
  - funct3 011 load -> resp_err 1 one cycle after accept, no mem_we.
  - ALLOW_MISALIGNED = 0 with LW at 0x101 -> resp_err 1, no memory access.
- Hold resp_ready low for 5 cycles -> response stable, req_ready 0. Then assert reset during ACC1 of a split store -> IDLE next cycle, mem_we 0, resp_valid 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// small helpers that decode access size and byte enables from funct3.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    function automatic logic [2:0] size_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_of = 3'd1;
            2'b01:   size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   be_of = 4'b0001;
            2'b01:   be_of = 4'b0011;
            default: be_of = 4'b1111;
        endcase
    endfunction

    // Stores only exist as SB/SH/SW; loads additionally allow LBU/LHU.
    function automatic logic f3_illegal(input logic [2:0] funct3, input logic we);
        if (we)
            f3_illegal = (funct3 > F3_W);
        else
            f3_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath: places store data and byte enables on a 64-bit
// lane window, and merges/extends the one or two words read for a load.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] wdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rd0_i,
    input  logic [31:0] rd1_i,
    output logic [63:0] lane_data_o,
    output logic [63:0] lane_mask_o,
    output logic [31:0] load_data_o
);

    logic [7:0]  lane_en;
    logic [63:0] merged;

    // Low word of the window feeds the first access, high word the second.
    always_comb begin
        lane_data_o = {32'h0, wdata_i} << {off_i, 3'b000};
        lane_en     = {4'h0, be_of(funct3_i)} << off_i;
        lane_mask_o = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask_o[8*i +: 8] = {8{lane_en[i]}};
        end
    end

    always_comb begin
        merged = {rd1_i, rd0_i} >> {off_i, 3'b000};
        case (funct3_i)
            F3_B:    load_data_o = {{24{merged[7]}}, merged[7:0]};
            F3_H:    load_data_o = {{16{merged[15]}}, merged[15:0]};
            F3_W:    load_data_o = merged[31:0];
            F3_BU:   load_data_o = {24'h0, merged[7:0]};
            F3_HU:   load_data_o = {16'h0, merged[15:0]};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store initiator: accepts one RV32 load/store, issues one or two word
// accesses on the data-memory port and returns a single registered response.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    output logic [31:0] mem_write_mask,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; valid and its payload stay stable until that edge.

    lsu_state_e  state_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic        split_q;
    logic [31:0] rd0_q;

    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;
    logic        mem_we_q;
    logic [31:0] mem_a_q;
    logic [31:0] mem_wd_q;
    logic [31:0] mem_mask_q;

    logic        in_idle;
    logic [3:0]  req_end;
    logic        req_split;
    logic        req_err;

    logic [31:0] al_wdata;
    logic [2:0]  al_f3;
    logic [1:0]  al_off;
    logic [31:0] al_rd0;
    logic [63:0] lane_data;
    logic [63:0] lane_mask;
    logic [31:0] load_data;

    assign in_idle   = (state_q == IDLE);
    assign req_end   = {2'b00, req_addr[1:0]} + {1'b0, size_of(req_funct3)};
    assign req_split = (req_end > 4'd4);
    assign req_err   = f3_illegal(req_funct3, req_we) || (req_split && !ALLOW_MISALIGNED);

    // In IDLE the datapath looks at the incoming request so the first access
    // can be registered on the accept edge; afterwards it uses the captures.
    assign al_wdata = in_idle ? req_wdata       : wdata_q;
    assign al_f3    = in_idle ? req_funct3      : f3_q;
    assign al_off   = in_idle ? req_addr[1:0]   : off_q;
    assign al_rd0   = (state_q == ACC0) ? mem_rd : rd0_q;

    lsu_align u_align (
        .wdata_i     (al_wdata),
        .funct3_i    (al_f3),
        .off_i       (al_off),
        .rd0_i       (al_rd0),
        .rd1_i       (mem_rd),
        .lane_data_o (lane_data),
        .lane_mask_o (lane_mask),
        .load_data_o (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            f3_q         <= F3_B;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            split_q      <= 1'b0;
            rd0_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_a_q      <= '0;
            mem_wd_q     <= '0;
            mem_mask_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        off_q   <= req_addr[1:0];
                        wdata_q <= req_wdata;
                        split_q <= req_split;
                        if (req_err) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q    <= ACC0;
                            mem_we_q   <= req_we;
                            mem_a_q    <= {req_addr[31:2], 2'b00};
                            mem_wd_q   <= lane_data[31:0];
                            mem_mask_q <= lane_mask[31:0];
                        end
                    end
                end
                ACC0: begin
                    rd0_q <= mem_rd;
                    if (split_q) begin
                        // Adding 4 to a word address wraps 0xFFFFFFFC to 0.
                        state_q    <= ACC1;
                        mem_a_q    <= mem_a_q + 32'd4;
                        mem_wd_q   <= lane_data[63:32];
                        mem_mask_q <= lane_mask[63:32];
                    end else begin
                        state_q      <= RESP;
                        mem_we_q     <= 1'b0;
                        mem_mask_q   <= '0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= we_q ? 32'h0 : load_data;
                    end
                end
                ACC1: begin
                    state_q      <= RESP;
                    mem_we_q     <= 1'b0;
                    mem_mask_q   <= '0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= we_q ? 32'h0 : load_data;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = in_idle;
    assign resp_valid     = resp_valid_q;
    assign resp_rdata     = resp_rdata_q;
    assign resp_err       = resp_err_q;
    assign mem_we         = mem_we_q;
    assign mem_a          = mem_a_q;
    assign mem_wd         = mem_wd_q;
    assign mem_write_mask = mem_mask_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a driver issues requests and queues expected
// writes/responses; a negedge monitor pops and compares them.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_write_mask, mem_rd;
    logic [1:0]  dbg_state;

    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [2:0]  m0_req_funct3;
    logic [31:0] m0_req_addr, m0_req_wdata;
    logic        m0_resp_valid, m0_resp_ready, m0_resp_err;
    logic [31:0] m0_resp_rdata;
    logic        m0_mem_we;
    logic [31:0] m0_mem_a, m0_mem_wd, m0_mem_write_mask, m0_mem_rd;
    logic [1:0]  m0_dbg_state;
    logic        m0_wrote;

    logic [31:0] mem_arr [0:255];
    logic [36:0] exp_q[$];   // {lat[3:0], err, rdata}
    logic [95:0] wr_q[$];    // {addr, wd, mask}

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit in_resp = 0;

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_write_mask(mem_write_mask), .mem_rd(mem_rd),
        .dbg_state(dbg_state)
    );

    lsu_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_m0 (
        .clk(clk), .reset(reset),
        .req_valid(m0_req_valid), .req_ready(m0_req_ready), .req_we(m0_req_we),
        .req_funct3(m0_req_funct3), .req_addr(m0_req_addr), .req_wdata(m0_req_wdata),
        .resp_valid(m0_resp_valid), .resp_ready(m0_resp_ready),
        .resp_rdata(m0_resp_rdata), .resp_err(m0_resp_err),
        .mem_we(m0_mem_we), .mem_a(m0_mem_a), .mem_wd(m0_mem_wd),
        .mem_write_mask(m0_mem_write_mask), .mem_rd(m0_mem_rd),
        .dbg_state(m0_dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: combinational read, masked write on the clock edge.
    assign mem_rd    = mem_arr[mem_a[9:2]];
    assign m0_mem_rd = 32'h1234_5678;

    always @(posedge clk) begin
        if (mem_we)
            mem_arr[mem_a[9:2]] <= (mem_arr[mem_a[9:2]] & ~mem_write_mask) | (mem_wd & mem_write_mask);
        cyc <= cyc + 1;
        if (req_valid && req_ready)
            acc_cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_resp(input int lat, input logic err, input logic [31:0] rdata);
        exp_q.push_back({lat[3:0], err, rdata});
    endtask

    task automatic exp_wr(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mask);
        wr_q.push_back({a, wd, mask});
    endtask

    // Driver: caller sits #1 after a rising edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        int n;
        n = 0;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic m0_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic exp_err, input logic [31:0] exp_rdata, input int exp_lat);
        int lat;
        int n;
        n = 0;
        while (!m0_req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        m0_req_valid  = 1'b1;
        m0_req_we     = we;
        m0_req_funct3 = f3;
        m0_req_addr   = a;
        m0_req_wdata  = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        m0_req_valid = 1'b0;
        lat = 1;
        while (!m0_resp_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("m0_lat", 32'(lat), 32'(exp_lat));
        chk("m0_err", {31'b0, m0_resp_err}, {31'b0, exp_err});
        chk("m0_rdata", m0_resp_rdata, exp_rdata);
        @(posedge clk); #1;
    endtask

    // Monitor: writes and responses are compared against the queues.
    initial begin
        logic [95:0] w;
        logic [36:0] e;
        forever begin
            @(negedge clk);
            if (m0_mem_we) m0_wrote = 1'b1;
            if (mem_we) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_write", mem_a, 32'hFFFF_FFFF);
                end else begin
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_a, w[95:64]);
                    chk("wr_data", mem_wd, w[63:32]);
                    chk("wr_mask", mem_write_mask, w[31:0]);
                end
            end
            if (reset) begin
                in_resp = 1'b0;
            end else if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", resp_rdata, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[0];
                    if (!in_resp) begin
                        in_resp = 1'b1;
                        chk("resp_lat", 32'(cyc - acc_cyc + 1), {28'b0, e[36:33]});
                    end
                    chk("resp_rdata", resp_rdata, e[31:0]);
                    chk("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
                    chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        in_resp = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        m0_wrote      = 1'b0;
        reset         = 1'b1;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_funct3    = F3_W;
        req_addr      = '0;
        req_wdata     = '0;
        resp_ready    = 1'b1;
        m0_req_valid  = 1'b0;
        m0_req_we     = 1'b0;
        m0_req_funct3 = F3_W;
        m0_req_addr   = '0;
        m0_req_wdata  = '0;
        m0_resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_state", {30'b0, dbg_state}, 32'(IDLE));
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        chk("rst_mask", mem_write_mask, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Aligned stores and readback
        exp_wr(32'h100, 32'hDEAD_BEEF, 32'hFFFF_FFFF); exp_resp(2, 1'b0, 32'h0);
        issue(1'b1, F3_W, 32'h100, 32'hDEAD_BEEF);
        exp_wr(32'h100, 32'hAB00_0000, 32'hFF00_0000); exp_resp(2, 1'b0, 32'h0);
        issue(1'b1, F3_B, 32'h103, 32'h0000_00AB);
        exp_resp(2, 1'b0, 32'hABAD_BEEF);
        issue(1'b0, F3_W, 32'h100, 32'h0);

        // Split store across the top of the address space
        exp_wr(32'hFFFF_FFFC, 32'h3344_0000, 32'hFFFF_0000);
        exp_wr(32'h0000_0000, 32'h0000_1122, 32'h0000_FFFF);
        exp_resp(3, 1'b0, 32'h0);
        issue(1'b1, F3_W, 32'hFFFF_FFFE, 32'h1122_3344);

        // Preload words for the load tests
        exp_wr(32'h100, 32'h80FF_1234, 32'hFFFF_FFFF); exp_resp(2, 1'b0, 32'h0);
        issue(1'b1, F3_W, 32'h100, 32'h80FF_1234);
        exp_wr(32'h104, 32'h0000_0056, 32'hFFFF_FFFF); exp_resp(2, 1'b0, 32'h0);
        issue(1'b1, F3_W, 32'h104, 32'h0000_0056);

        // Loads: extension and split merge
        exp_resp(3, 1'b0, 32'h0000_5680); issue(1'b0, F3_H,  32'h103, 32'h0);
        exp_resp(2, 1'b0, 32'hFFFF_FFFF); issue(1'b0, F3_B,  32'h102, 32'h0);
        exp_resp(2, 1'b0, 32'h0000_0080); issue(1'b0, F3_BU, 32'h103, 32'h0);
        exp_resp(2, 1'b0, 32'h0000_80FF); issue(1'b0, F3_HU, 32'h102, 32'h0);
        exp_resp(2, 1'b0, 32'hFFFF_80FF); issue(1'b0, F3_H,  32'h102, 32'h0);
        exp_resp(3, 1'b0, 32'h0056_80FF); issue(1'b0, F3_W,  32'h102, 32'h0);

        // Halfword stores: in-word and word-crossing
        exp_wr(32'h100, 32'h00CA_FE00, 32'h00FF_FF00); exp_resp(2, 1'b0, 32'h0);
        issue(1'b1, F3_H, 32'h101, 32'h0000_CAFE);
        exp_resp(2, 1'b0, 32'h80CA_FE34); issue(1'b0, F3_W, 32'h100, 32'h0);
        exp_wr(32'h100, 32'hEF00_0000, 32'hFF00_0000);
        exp_wr(32'h104, 32'h0000_00BE, 32'h0000_00FF);
        exp_resp(3, 1'b0, 32'h0);
        issue(1'b1, F3_H, 32'h103, 32'h0000_BEEF);
        exp_resp(2, 1'b0, 32'hEFCA_FE34); issue(1'b0, F3_W,  32'h100, 32'h0);
        exp_resp(3, 1'b0, 32'h0000_BEEF); issue(1'b0, F3_HU, 32'h103, 32'h0);
        exp_resp(2, 1'b0, 32'hFFFF_FFBE); issue(1'b0, F3_B,  32'h104, 32'h0);

        // Illegal funct3: one-cycle error, no memory access
        exp_resp(1, 1'b1, 32'h0); issue(1'b0, 3'b011, 32'h100, 32'h0);
        exp_resp(1, 1'b1, 32'h0); issue(1'b1, 3'b100, 32'h100, 32'h1111_1111);
        exp_resp(1, 1'b1, 32'h0); issue(1'b0, 3'b110, 32'h100, 32'h0);
        exp_resp(1, 1'b1, 32'h0); issue(1'b1, 3'b111, 32'h100, 32'h2222_2222);
        wait_done();

        // Response held while consumer stalls
        resp_ready = 1'b0;
        exp_resp(2, 1'b0, 32'h0000_00BE);
        issue(1'b0, F3_W, 32'h104, 32'h0);
        repeat (6) begin
            @(posedge clk); #1;
        end
        chk("hold_valid", {31'b0, resp_valid}, 32'd1);
        chk("hold_state", {30'b0, dbg_state}, 32'(RESP));
        resp_ready = 1'b1;
        wait_done();

        // Misaligned requests with splitting disabled
        m0_op(1'b0, F3_W, 32'h101, 1'b1, 32'h0, 1);
        m0_op(1'b0, F3_H, 32'h103, 1'b1, 32'h0, 1);
        m0_op(1'b1, F3_W, 32'h102, 1'b1, 32'h0, 1);
        m0_op(1'b0, F3_W, 32'h100, 1'b0, 32'h1234_5678, 2);
        m0_op(1'b0, F3_H, 32'h102, 1'b0, 32'h0000_1234, 2);
        chk("m0_no_write", {31'b0, m0_wrote}, 32'd0);

        // Reset during the second access of a split store
        exp_wr(32'h104, 32'h7788_0000, 32'hFFFF_0000);
        exp_wr(32'h108, 32'h0000_5566, 32'h0000_FFFF);
        issue(1'b1, F3_W, 32'h106, 32'h5566_7788);
        chk("abort_acc0", {30'b0, dbg_state}, 32'(ACC0));
        @(posedge clk); #1;
        chk("abort_acc1", {30'b0, dbg_state}, 32'(ACC1));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_idle", {30'b0, dbg_state}, 32'(IDLE));
        chk("abort_mem_we", {31'b0, mem_we}, 32'd0);
        chk("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("abort_mask", mem_write_mask, 32'd0);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("abort_writes_left", 32'(wr_q.size()), 32'd0);
        chk("abort_resps_left", 32'(exp_q.size()), 32'd0);
        chk("abort_mem104", mem_arr[65], 32'h7788_00BE);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
